ones_run_generator: RTL and testbench
=====================================

// Module: ones_run_generator
// PURPOSE
//  Serial stimulus source for the consecutive-ones run counter: emits a 1-bit
//  stream containing a programmed number of runs of ones, each run_len bits
//  long, separated and terminated by gap_len zeros. Drives the counter's din,
//  so its final count equals num_runs. Used as link-side transmitter in
//  loopback and BIST.
// PARAMETERS
//  CNT_W  8  width of num_runs / runs_sent (max runs = 2**CNT_W-1)
//  LEN_W  4  width of run_len / gap_len (bits per run / per gap)
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst        in   1      reset, synchronous, active-high
//  start      in   1      request a burst; sampled only in IDLE
//  num_runs   in   CNT_W  runs of ones to emit; latched on accepted start
//  run_len    in   LEN_W  ones per run; latched; 0 treated as 1
//  gap_len    in   LEN_W  zeros after each run; latched; 0 treated as 1
//  dout       out  1      serial data, registered
//  busy       out  1      high while a burst is in progress
//  done       out  1      one-cycle pulse after final trailing zero
//  runs_sent  out  CNT_W  runs fully emitted in current/last burst
// BEHAVIOUR
//  Reset: dout=0, busy=0, done=0, runs_sent=0, state=IDLE, latches cleared.
//  States: IDLE, ONES, ZEROS, FIN.
//  IDLE: dout=0. start=1 at edge t -> latch operands; if num_runs!=0 go ONES,
//   dout=1 and busy=1 from cycle t+1, runs_sent cleared to 0.
//   If num_runs==0 go FIN directly: no ones, done=1 in cycle t+1.
//  ONES: dout=1 for exactly max(run_len,1) cycles; on last cycle go ZEROS,
//   runs_sent increments on the ONES->ZEROS edge.
//  ZEROS: dout=0 for exactly max(gap_len,1) cycles; on last cycle: if
//   runs_sent==num_runs go FIN else go ONES. Final run always followed by a
//   full gap so the receiver closes the last run.
//  FIN: busy=0, done=1 for one cycle, dout=0; next state IDLE.
//  start is ignored while busy=1 or in FIN; operand changes during a burst
//   have no effect. start in the IDLE cycle after FIN is accepted normally.
//  Burst length (start edge to done) = num_runs*(R+G)+1 cycles, R/G = lengths
//   after 0->1 substitution.
//  Bit-length timer: LEN_W down-counter loaded with R-1 / G-1; no wrap.
//  runs_sent never exceeds num_runs; holds value after FIN until next start.
//  rst asserted mid-burst: next edge returns to reset values, no done pulse.
// STRUCTURE
//  Package ones_run_pkg: state enum {IDLE,ONES,ZEROS,FIN}, default CNT_W/LEN_W.
//  One sub-module: run_len_timer (loadable LEN_W down-counter, 'last' flag),
//   instanced once, reloaded on every ONES/ZEROS entry.
//  Top: FSM, operand latches, runs_sent counter, registered dout/busy/done.
// TESTING
//  rst=1 mid-burst (num_runs=5, after 2 runs) -> next cycle dout=0,busy=0,
//   runs_sent=0, no done; fresh start then completes normally.
//  num_runs=3,run_len=2,gap_len=1 -> dout 110110110, done at cycle 10,
//   runs_sent=3; counter fed by dout reads 3.
//  num_runs=0 -> no ones emitted, done pulse 1 cycle after start, busy never 1.
//  run_len=0,gap_len=0,num_runs=4 -> treated as 1/1: dout 10101010, done cyc 9.
//  start held high through burst num_runs=2,run_len=3,gap_len=2 -> one burst
//   11100 11100, second accepted only in IDLE after FIN.
//  num_runs=255,run_len=15,gap_len=15 -> runs_sent=255, no wrap, burst 7651.

Source files
------------

// File: rtl/ones_run_pkg.sv
// Shared types and defaults for the ones-run stimulus generator.
package ones_run_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ONES,
        ZEROS,
        FIN
    } state_t;

endpackage

// File: rtl/ones_run_generator_timer.sv
// Loadable down-counter timing one run or one gap; last marks its final bit.
module run_len_timer #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    output logic             last
);

    logic [LEN_W-1:0] cnt;

    // Holds at zero rather than wrapping between reloads
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/ones_run_generator.sv
// Serial burst source: num_runs runs of run_len ones, each followed by
// gap_len zeros, then a one-cycle done pulse.
module ones_run_generator
    import ones_run_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_runs,
    input  logic [LEN_W-1:0] run_len,
    input  logic [LEN_W-1:0] gap_len,
    output logic             dout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] runs_sent
);

    state_t           state, state_n;
    logic [CNT_W-1:0] nruns_q;
    logic [LEN_W-1:0] rm1_q, gm1_q;
    logic [LEN_W-1:0] rm1_in, gm1_in;
    logic             accept, inc, load, last;
    logic [LEN_W-1:0] load_val;

    // Lengths stored minus one; a zero length behaves as one
    assign rm1_in = (run_len == '0) ? '0 : run_len - 1'b1;
    assign gm1_in = (gap_len == '0) ? '0 : gap_len - 1'b1;

    run_len_timer #(.LEN_W(LEN_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .last     (last)
    );

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        inc      = 1'b0;
        load     = 1'b0;
        load_val = rm1_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (num_runs != '0) begin
                        state_n  = ONES;
                        load     = 1'b1;
                        load_val = rm1_in;
                    end else begin
                        state_n = FIN;
                    end
                end
            end
            ONES: begin
                if (last) begin
                    state_n  = ZEROS;
                    inc      = 1'b1;
                    load     = 1'b1;
                    load_val = gm1_q;
                end
            end
            ZEROS: begin
                if (last) begin
                    if (runs_sent == nruns_q) begin
                        state_n = FIN;
                    end else begin
                        state_n  = ONES;
                        load     = 1'b1;
                        load_val = rm1_q;
                    end
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            runs_sent <= '0;
            nruns_q   <= '0;
            rm1_q     <= '0;
            gm1_q     <= '0;
        end else begin
            state <= state_n;
            dout  <= (state_n == ONES);
            busy  <= (state_n == ONES) || (state_n == ZEROS);
            done  <= (state_n == FIN);
            if (accept) begin
                nruns_q   <= num_runs;
                rm1_q     <= rm1_in;
                gm1_q     <= gm1_in;
                runs_sent <= '0;
            end else if (inc) begin
                runs_sent <= runs_sent + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ones_run_generator.sv
// Scoreboard bench: driver queues expected bursts, monitor checks on done.
module tb_ones_run_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_runs;
    logic [3:0] run_len;
    logic [3:0] gap_len;
    logic       dout;
    logic       busy;
    logic       done;
    logic [7:0] runs_sent;

    ones_run_generator #(.CNT_W(8), .LEN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_runs  (num_runs),
        .run_len   (run_len),
        .gap_len   (gap_len),
        .dout      (dout),
        .busy      (busy),
        .done      (done),
        .runs_sent (runs_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t0;
        int          len;
        int          nbits;
        int          ones;
        int          runs;
        logic [63:0] pat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: gathers the serial stream while busy, scores it on done
    logic [63:0] m_pat = '0;
    int          m_nb = 0;
    int          m_ones = 0;
    int          m_runs = 0;
    logic        m_prev = 1'b0;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            m_pat = '0; m_nb = 0; m_ones = 0; m_runs = 0; m_prev = 1'b0;
        end else begin
            if (busy) begin
                m_pat = {m_pat[62:0], dout};
                m_nb++;
                if (dout) m_ones++;
                if (m_prev && !dout) m_runs++;
                m_prev = dout;
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("burst_len", cyc - e.t0, e.len);
                    chk("busy_bits", m_nb, e.nbits);
                    chk("ones_bits", m_ones, e.ones);
                    chk("rx_run_count", m_runs, e.runs);
                    chk("runs_sent", runs_sent, e.runs);
                    chk("busy_at_done", busy, 0);
                    if (e.nbits <= 64) chk("pattern", m_pat, e.pat);
                end
                m_pat = '0; m_nb = 0; m_ones = 0; m_runs = 0; m_prev = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (!(q.size() == 0 && !busy && !done)) begin
            @(negedge clk);
            k++;
            if (k > 20000) begin
                chk("idle_timeout", 0, 1);
                q.delete();
                break;
            end
        end
    endtask

    function automatic exp_t mk(int t0, int n, int r, int g, logic [63:0] pat);
        exp_t x;
        int rr = (r == 0) ? 1 : r;
        int gg = (g == 0) ? 1 : g;
        x.t0    = t0;
        x.len   = n * (rr + gg);
        x.nbits = n * (rr + gg);
        x.ones  = n * rr;
        x.runs  = n;
        x.pat   = pat;
        return x;
    endfunction

    task automatic issue(int n, int r, int g, logic [63:0] pat);
        wait_idle();
        num_runs = 8'(n);
        run_len  = 4'(r);
        gap_len  = 4'(g);
        start    = 1'b1;
        q.push_back(mk(cyc + 1, n, r, g, pat));
        @(negedge clk);
        start    = 1'b0;
        num_runs = 8'hAA;
        run_len  = 4'h7;
        gap_len  = 4'h9;
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0;
        num_runs = '0; run_len = '0; gap_len = '0;
        repeat (2) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_runs_sent", runs_sent, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(3, 2, 1, 64'b110110110);
        issue(0, 5, 5, 64'b0);
        issue(4, 0, 0, 64'b10101010);

        // start held high: second burst only after FIN then IDLE
        wait_idle();
        num_runs = 8'd2; run_len = 4'd3; gap_len = 4'd2; start = 1'b1;
        q.push_back(mk(cyc + 1, 2, 3, 2, 64'b1110011100));
        q.push_back(mk(cyc + 13, 2, 3, 2, 64'b1110011100));
        k = 0;
        while (!(q.size() == 1 && busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("restart_seen", k < 200, 1);
        start = 1'b0;

        // reset in the middle of a burst
        wait_idle();
        num_runs = 8'd5; run_len = 4'd2; gap_len = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (runs_sent != 8'd2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("two_runs_reached", runs_sent, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_dout", dout, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_runs_sent", runs_sent, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done, 0);
        issue(1, 1, 3, 64'b1000);

        issue(255, 15, 15, 64'b0);

        wait_idle();
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
